stream_pkt_arb: RTL and testbench
=================================

STREAM_PKT_ARB -- requirements
Module: stream_pkt_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 26, the total beat width: bit DATA_WIDTH-1 = SOP, bit DATA_WIDTH-2 = EOP, remaining low bits = pixel payload.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports s0_valid (input, 1), s0_ready (output, 1) and s0_data (input, DATA_WIDTH): source 0 stream.
REQ-006 SHALL have ports s1_valid (input, 1), s1_ready (output, 1) and s1_data (input, DATA_WIDTH): source 1 stream.
REQ-007 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, DATA_WIDTH): merged output stream.
REQ-008 SHALL have port grant, output, 2 bits: one-hot owner of the output; 00 = none.
REQ-009 SHALL have ports pkt_cnt0 and pkt_cnt1, output, CNT_WIDTH each, and drop_cnt, output, CNT_WIDTH; present only with STREAM_ARB_STATS_EN.

Function
REQ-010 A beat SHALL transfer on an interface when valid and ready are both high in the same cycle.
REQ-011 The output SHALL be one register stage: load when ~m_valid | m_ready; m_valid stays high and m_data stays stable until accepted.
REQ-012 Latency SHALL be exactly 1 cycle from source transfer to m_valid.
REQ-013 The FSM SHALL have states IDLE, GRANT0 and GRANT1; grant = 00, 01 and 10 respectively.
REQ-014 In IDLE, a source is eligible when its valid and SOP bits are both high.
REQ-015 In IDLE with one eligible source, the arbiter SHALL grant it and transfer its SOP beat in the same cycle.
REQ-016 In IDLE with both sources eligible, the arbiter SHALL grant the source other than last_grant (round-robin).
REQ-017 In GRANTn, only source n SHALL have ready, equal to ~m_valid | m_ready; the other source's ready is 0.
REQ-018 In GRANTn, a transferred beat with EOP = 1 SHALL return the FSM to IDLE next cycle and set last_grant = n.
- A single-beat packet (SOP and EOP both 1) therefore leaves the FSM in IDLE after one cycle.
REQ-019 In IDLE, a source with valid = 1 and SOP = 0 SHALL see ready = 1; the beat is discarded and not forwarded.
REQ-020 A mid-packet SOP in GRANTn SHALL be forwarded unmodified; no packet repair is performed.
REQ-021 In GRANTn, source n valid = 0 SHALL hold the grant indefinitely (no timeout); m_valid drops after the held beat drains.
REQ-022 Back-to-back packets SHALL incur exactly one IDLE cycle between the EOP beat and the next SOP transfer.

Reset
REQ-023 On rst the block SHALL set: state = IDLE, last_grant = 1 (source 0 wins the first tie), m_valid = 0, m_data = 0, s0_ready = s1_ready = 0, and all counters = 0.
REQ-024 Reset mid-packet SHALL abandon the packet with no EOP emitted; ready is 0 during reset.

Configuration
REQ-025 Macro STREAM_ARB_STATS_EN defined: pkt_cnt0 and pkt_cnt1 increment on each forwarded EOP from their source; drop_cnt increments per beat discarded under REQ-019; all counters wrap at 2^CNT_WIDTH.
REQ-026 Macro STREAM_ARB_STATS_EN undefined: the counter ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package stream_pkg SHALL hold the SOP_BIT and EOP_BIT position constants, the default DATA_WIDTH, and the arb_state_t enum.
REQ-028 The output register SHALL be sub-module stream_arb_oreg (valid/ready/data, DATA_WIDTH-parameterised); the FSM and mux live in stream_pkt_arb.

Verification
REQ-029 Single source: s0 sends 4 beats 0x2000001..0x1000004 (SOP first, EOP last), m_ready = 1 -> m_data carries the same 4 beats 1 cycle later; grant = 01 then 00.
REQ-030 Tie: both sources present SOP in the first cycle after reset -> s0 granted; after its EOP and the IDLE cycle, s1 is granted while s0 is held off.
REQ-031 Backpressure: m_ready = 0 for 3 cycles mid-packet -> m_data is held stable, s0_ready = 0, and no beat is lost or duplicated.
REQ-032 Orphan: s1 sends 2 beats without SOP while in IDLE -> neither is forwarded; drop_cnt = 2 with STREAM_ARB_STATS_EN.
REQ-033 Reset: rst asserted mid-packet -> m_valid = 0 and grant = 00 the next cycle; a new SOP on s1 is then granted.
REQ-034 Wrap: CNT_WIDTH = 4 with 17 s0 packets -> pkt_cnt0 = 1.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: shared beat-field positions, default width and arbiter state encoding for stream_pkt_arb.
package stream_pkg;
    localparam int DEF_DATA_WIDTH = 26;
    localparam int SOP_BIT = DEF_DATA_WIDTH - 1;
    localparam int EOP_BIT = DEF_DATA_WIDTH - 2;
    // Encodings double as the one-hot grant output.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_t;
endpackage

// File: rtl/stream_arb_oreg.sv
// stream_arb_oreg: single valid/ready register stage; holds data stable until the sink accepts it.
module stream_arb_oreg #(
    parameter int DATA_WIDTH = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    always_comb begin
        valid_d = in_ready_o ? in_valid_i : valid_q;
        data_d  = (in_ready_o & in_valid_i) ? in_data_i : data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/stream_pkt_arb.sv
// stream_pkt_arb: two-source packet-granular round-robin arbiter with a registered output stage.
// Optional statistics counters are built when STREAM_ARB_STATS_EN is defined.
module stream_pkt_arb
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [DATA_WIDTH-1:0] s1_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef STREAM_ARB_STATS_EN
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
`endif
    output logic [1:0]            grant
);
    localparam int SOP = DATA_WIDTH - DEF_DATA_WIDTH + SOP_BIT;
    localparam int EOP = DATA_WIDTH - DEF_DATA_WIDTH + EOP_BIT;
    arb_state_t            state_q, state_d;
    logic                  last_q, last_d;
    logic                  acc, e0, e1, idle, pick1, sel_valid, sel_ready, hit;
    logic [DATA_WIDTH-1:0] sel_data;
    assign idle  = state_q == IDLE;
    assign e0    = s0_valid & s0_data[SOP];
    assign e1    = s1_valid & s1_data[SOP];
    assign grant = state_q;
    // In IDLE a tie goes to the source that did not own the last packet.
    assign pick1 = idle ? e1 & (~e0 | ~last_q) : state_q == GRANT1;
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (!rst) begin
            s0_ready = idle ? (e0 ? ~pick1 & acc : 1'b1) : ~pick1 & acc;
            s1_ready = idle ? (e1 ? pick1 & acc : 1'b1) : pick1 & acc;
        end
    end
    assign sel_valid = pick1 ? s1_valid : s0_valid;
    assign sel_ready = pick1 ? s1_ready : s0_ready;
    assign sel_data  = pick1 ? s1_data : s0_data;
    // Non-SOP beats accepted in IDLE are discards, never forwarded.
    assign hit = sel_valid & sel_ready & (~idle | sel_data[SOP]);
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (hit) begin
            state_d = sel_data[EOP] ? IDLE : (pick1 ? GRANT1 : GRANT0);
            last_d  = sel_data[EOP] ? pick1 : last_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end
    stream_arb_oreg #(.DATA_WIDTH(DATA_WIDTH)) u_oreg (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (hit),
        .in_ready_o (acc),
        .in_data_i  (sel_data),
        .out_valid_o(m_valid),
        .out_ready_i(m_ready),
        .out_data_o (m_data)
    );
`ifdef STREAM_ARB_STATS_EN
    logic                 d0, d1, eop0, eop1;
    logic [CNT_WIDTH-1:0] pkt0_q, pkt1_q, drop_q;
    assign d0   = idle & s0_valid & s0_ready & ~s0_data[SOP];
    assign d1   = idle & s1_valid & s1_ready & ~s1_data[SOP];
    assign eop0 = hit & ~pick1 & sel_data[EOP];
    assign eop1 = hit & pick1 & sel_data[EOP];
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt0_q <= '0;
            pkt1_q <= '0;
            drop_q <= '0;
        end else begin
            pkt0_q <= pkt0_q + CNT_WIDTH'(eop0);
            pkt1_q <= pkt1_q + CNT_WIDTH'(eop1);
            drop_q <= drop_q + CNT_WIDTH'(d0) + CNT_WIDTH'(d1);
        end
    end
    assign pkt_cnt0 = pkt0_q;
    assign pkt_cnt1 = pkt1_q;
    assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_stream_pkt_arb.sv
// tb_stream_pkt_arb: directed self-checking bench for stream_pkt_arb (counter checks need STREAM_ARB_STATS_EN).
module tb_stream_pkt_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_valid = 1'b0, s1_valid = 1'b0, m_ready = 1'b1;
    logic        s0_ready, s1_ready, m_valid;
    logic [25:0] s0_data = '0, s1_data = '0, m_data;
    logic [1:0]  grant;
`ifdef STREAM_ARB_STATS_EN
    logic [3:0]  pkt_cnt0, pkt_cnt1, drop_cnt;
`endif
    int errors = 0;
    int checks = 0;

    stream_pkt_arb #(.DATA_WIDTH(26), .CNT_WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .s0_valid(s0_valid),
        .s0_ready(s0_ready),
        .s0_data (s0_data),
        .s1_valid(s1_valid),
        .s1_ready(s1_ready),
        .s1_data (s1_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
`ifdef STREAM_ARB_STATS_EN
        .pkt_cnt0(pkt_cnt0),
        .pkt_cnt1(pkt_cnt1),
        .drop_cnt(drop_cnt),
`endif
        .grant   (grant)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic out(input string tag, input logic v, input logic [25:0] d, input logic [1:0] g);
        chk({tag, "_valid"}, 32'(m_valid), 32'(v));
        if (v) chk({tag, "_data"}, 32'(m_data), 32'(d));
        chk({tag, "_grant"}, 32'(grant), 32'(g));
    endtask

    initial begin
        tick;
        tick;
        out("rst", 1'b0, '0, 2'b00);
        chk("rst_mdata", 32'(m_data), 32'h0);
        chk("rst_rdy0", 32'(s0_ready), 32'h0);
        chk("rst_rdy1", 32'(s1_ready), 32'h0);
        rst = 1'b0;
        // single source, four beats
        s0_valid = 1'b1; s0_data = 26'h2000001; #1;
        chk("s1_rdy_sop", 32'(s0_ready), 32'h1);
        tick; out("s1_b1", 1'b1, 26'h2000001, 2'b01);
        s0_data = 26'h0000002; #1;
        chk("s1_rdy_mid", 32'(s0_ready), 32'h1);
        tick; out("s1_b2", 1'b1, 26'h0000002, 2'b01);
        s0_data = 26'h0000003;
        tick; out("s1_b3", 1'b1, 26'h0000003, 2'b01);
        s0_data = 26'h1000004;
        tick; out("s1_b4", 1'b1, 26'h1000004, 2'b00);
        s0_valid = 1'b0;
        tick; out("s1_drain", 1'b0, '0, 2'b00);
        // tie right after reset: s0 first, then s1 via round-robin
        rst = 1'b1; tick; rst = 1'b0;
        s0_valid = 1'b1; s0_data = 26'h2000011;
        s1_valid = 1'b1; s1_data = 26'h2000021; #1;
        chk("tie_rdy0", 32'(s0_ready), 32'h1);
        chk("tie_rdy1", 32'(s1_ready), 32'h0);
        tick; out("tie_p0a", 1'b1, 26'h2000011, 2'b01);
        s0_data = 26'h1000012; #1;
        chk("tie_hold1", 32'(s1_ready), 32'h0);
        tick; out("tie_p0b", 1'b1, 26'h1000012, 2'b00);
        s0_data = 26'h2000013; #1;
        chk("rr_rdy1", 32'(s1_ready), 32'h1);
        chk("rr_rdy0", 32'(s0_ready), 32'h0);
        tick; out("rr_p1a", 1'b1, 26'h2000021, 2'b10);
        s1_data = 26'h1000022; #1;
        chk("rr_hold0", 32'(s0_ready), 32'h0);
        tick; out("rr_p1b", 1'b1, 26'h1000022, 2'b00);
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick; out("rr_drain", 1'b0, '0, 2'b00);
        // backpressure mid-packet
        s0_valid = 1'b1; s0_data = 26'h2000031;
        tick; out("bp_b1", 1'b1, 26'h2000031, 2'b01);
        s0_data = 26'h0000032;
        tick; out("bp_b2", 1'b1, 26'h0000032, 2'b01);
        m_ready = 1'b0; s0_data = 26'h0000033;
        for (int i = 0; i < 3; i++) begin
            #1; chk("bp_rdy0", 32'(s0_ready), 32'h0);
            tick; out("bp_hold", 1'b1, 26'h0000032, 2'b01);
        end
        m_ready = 1'b1; #1;
        chk("bp_rel_rdy", 32'(s0_ready), 32'h1);
        tick; out("bp_b3", 1'b1, 26'h0000033, 2'b01);
        s0_data = 26'h1000034;
        tick; out("bp_b4", 1'b1, 26'h1000034, 2'b00);
        s0_valid = 1'b0;
        tick; out("bp_drain", 1'b0, '0, 2'b00);
`ifdef STREAM_ARB_STATS_EN
        chk("cnt_pkt0", 32'(pkt_cnt0), 32'd2);
        chk("cnt_pkt1", 32'(pkt_cnt1), 32'd1);
`endif
        // orphan beats in IDLE are discarded
        s1_valid = 1'b1; s1_data = 26'h0000041; #1;
        chk("orph_rdy", 32'(s1_ready), 32'h1);
        tick; out("orph_1", 1'b0, '0, 2'b00);
        s1_data = 26'h0000042;
        tick; out("orph_2", 1'b0, '0, 2'b00);
        s1_valid = 1'b0;
`ifdef STREAM_ARB_STATS_EN
        chk("cnt_drop", 32'(drop_cnt), 32'd2);
`endif
        // reset mid-packet, then s1 gets the output
        s0_valid = 1'b1; s0_data = 26'h2000051;
        tick; out("rm_b1", 1'b1, 26'h2000051, 2'b01);
        s0_data = 26'h0000052; rst = 1'b1; #1;
        chk("rm_rdy0", 32'(s0_ready), 32'h0);
        tick; out("rm_rst", 1'b0, '0, 2'b00);
        rst = 1'b0; s0_valid = 1'b0;
        s1_valid = 1'b1; s1_data = 26'h2000061; #1;
        chk("rm_rdy1", 32'(s1_ready), 32'h1);
        tick; out("rm_s1a", 1'b1, 26'h2000061, 2'b10);
        s1_data = 26'h1000062;
        tick; out("rm_s1b", 1'b1, 26'h1000062, 2'b00);
        s1_valid = 1'b0;
        tick; out("rm_drain", 1'b0, '0, 2'b00);
        // 17 single-beat packets back to back from s0
        s0_valid = 1'b1; s0_data = 26'h3000070;
        for (int i = 0; i < 17; i++) begin
            tick; out("sb", 1'b1, 26'h3000070, 2'b00);
        end
        s0_valid = 1'b0;
        tick;
`ifdef STREAM_ARB_STATS_EN
        chk("wrap_pkt0", 32'(pkt_cnt0), 32'd1);
        chk("wrap_pkt1", 32'(pkt_cnt1), 32'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
